// File: rtl/disp_page_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : disp_page_arbiter_if
//  Description : Bus between the display requesters (temperature, status,
//                alarm) and the page arbiter that drives the 4-digit
//                seven-segment scanner.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Signals
//    req[2:0]     page requests, level: bit0 temp, bit1 status, bit2 alarm
//    temp_bcd[7:0] temperature, [7:4] tens, [3:0] units (BCD)
//    status[3:0]  FSM status code
//    warning      makes the status digit blink
//    gnt[2:0]     one-hot grant (zero when idle)
//    dig0..dig3   digit codes, dig0 rightmost
//    blank[3:0]   per-digit blank, 1 = off, bit n for digN
//    page_done    one-cycle pulse when a temperature/status dwell expires
//  Modports
//    master : requester / scanner side
//    slave  : arbiter side
// ============================================================================
interface disp_page_arbiter_if;
  logic [2:0] req;
  logic [7:0] temp_bcd;
  logic [3:0] status;
  logic       warning;
  logic [2:0] gnt;
  logic [3:0] dig0;
  logic [3:0] dig1;
  logic [3:0] dig2;
  logic [3:0] dig3;
  logic [3:0] blank;
  logic       page_done;

  modport master (
    output req, temp_bcd, status, warning,
    input  gnt, dig0, dig1, dig2, dig3, blank, page_done
  );

  modport slave (
    input  req, temp_bcd, status, warning,
    output gnt, dig0, dig1, dig2, dig3, blank, page_done
  );
endinterface
`default_nettype wire

// File: rtl/disp_page_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : disp_page_arbiter
//  Description : Shares the 4-digit seven-segment display between the
//                temperature readout, the status code and the alarm banner.
//                Alarm pre-empts; temperature and status round-robin on a
//                dwell timer; alarm and warning pages blink.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    DWELL : cycles a temperature/status page is held (min 2)
//    BLINK : cycles per blink half-period (min 1)
//    CW    : width of dwell/blink counters, must hold DWELL-1 and BLINK-1
//  Ports
//    clock : system clock, rising edge
//    clr   : asynchronous active-high reset
//    bus   : disp_page_arbiter_if.slave (requests, page data, grant,
//            registered digit codes, blank mask, page_done)
// ============================================================================
module disp_page_arbiter #(
  parameter int DWELL = 25000000,
  parameter int BLINK = 12500000,
  parameter int CW    = 25
) (
  input  logic                  clock,
  input  logic                  clr,
  disp_page_arbiter_if.slave    bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_TEMP  = 2'd1,
    S_STAT  = 2'd2,
    S_ALARM = 2'd3
  } state_t;

  state_t          state_q, state_d;
  state_t          resume_q, resume_d;   // only ever S_TEMP or S_STAT
  logic [CW-1:0]   dwell_q, dwell_d;
  logic [CW-1:0]   blink_cnt_q, blink_cnt_d;
  logic            blink_phase_q, blink_phase_d;
  logic [2:0]      gnt_q, gnt_d;
  logic [3:0]      dig0_q, dig0_d;
  logic [3:0]      dig1_q, dig1_d;
  logic [3:0]      dig2_q, dig2_d;
  logic [3:0]      dig3_q, dig3_d;
  logic [3:0]      blank_q, blank_d;
  logic            expire;

  // Page-relative views of the request vector.
  logic            own_req, oth_req, resume_req, alt_req;
  state_t          oth_page, alt_page;

  always_comb begin
    own_req    = (state_q == S_STAT) ? bus.req[1] : bus.req[0];
    oth_req    = (state_q == S_STAT) ? bus.req[0] : bus.req[1];
    oth_page   = (state_q == S_STAT) ? S_TEMP : S_STAT;
    resume_req = (resume_q == S_STAT) ? bus.req[1] : bus.req[0];
    alt_req    = (resume_q == S_STAT) ? bus.req[0] : bus.req[1];
    alt_page   = (resume_q == S_STAT) ? S_TEMP : S_STAT;
  end

  // Free-running blink timer, independent of which page is shown.
  always_comb begin
    blink_cnt_d   = blink_cnt_q + CW'(1);
    blink_phase_d = blink_phase_q;
    if (blink_cnt_q == CW'(BLINK - 1)) begin
      blink_cnt_d   = '0;
      blink_phase_d = ~blink_phase_q;
    end
  end

  // Page selection and dwell timing.
  always_comb begin
    state_d  = state_q;
    resume_d = resume_q;
    dwell_d  = dwell_q;
    expire   = 1'b0;
    if (bus.req[2]) begin
      // Alarm wins over everything, including a dwell expiring this cycle.
      state_d = S_ALARM;
      dwell_d = '0;
      if ((state_q == S_TEMP) || (state_q == S_STAT)) begin
        resume_d = state_q;
      end
    end else begin
      case (state_q)
        S_IDLE, S_ALARM: begin
          // Both entries pick the remembered page first, then the other one.
          dwell_d = '0;
          if (resume_req) begin
            state_d = resume_q;
          end else if (alt_req) begin
            state_d = alt_page;
          end else begin
            state_d = S_IDLE;
          end
        end
        default: begin
          if (!own_req) begin
            dwell_d = '0;
            state_d = oth_req ? oth_page : S_IDLE;
          end else if (dwell_q == CW'(DWELL - 1)) begin
            expire  = 1'b1;
            dwell_d = '0;
            if (oth_req) begin
              state_d = oth_page;
            end
          end else begin
            dwell_d = dwell_q + CW'(1);
          end
        end
      endcase
    end
  end

  // Page content for the state being entered, using the blink phase that
  // becomes current on the same edge so blank and phase stay coherent.
  always_comb begin
    gnt_d   = 3'b000;
    dig0_d  = 4'h0;
    dig1_d  = 4'h0;
    dig2_d  = 4'h0;
    dig3_d  = 4'h0;
    blank_d = 4'hF;
    case (state_d)
      S_TEMP: begin
        gnt_d   = 3'b001;
        dig3_d  = 4'hC;
        dig1_d  = bus.temp_bcd[7:4];
        dig0_d  = bus.temp_bcd[3:0];
        blank_d = 4'b0100;
      end
      S_STAT: begin
        gnt_d   = 3'b010;
        dig0_d  = bus.status;
        blank_d = (bus.warning && blink_phase_d) ? 4'b1111 : 4'b1110;
      end
      S_ALARM: begin
        gnt_d   = 3'b100;
        dig3_d  = 4'hA;
        dig2_d  = 4'hA;
        dig0_d  = bus.status;
        blank_d = blink_phase_d ? 4'b1111 : 4'b0010;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge clr) begin
    if (clr) begin
      state_q       <= S_IDLE;
      resume_q      <= S_TEMP;
      dwell_q       <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      gnt_q         <= 3'b000;
      dig0_q        <= 4'h0;
      dig1_q        <= 4'h0;
      dig2_q        <= 4'h0;
      dig3_q        <= 4'h0;
      blank_q       <= 4'hF;
    end else begin
      state_q       <= state_d;
      resume_q      <= resume_d;
      dwell_q       <= dwell_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      gnt_q         <= gnt_d;
      dig0_q        <= dig0_d;
      dig1_q        <= dig1_d;
      dig2_q        <= dig2_d;
      dig3_q        <= dig3_d;
      blank_q       <= blank_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.dig0      = dig0_q;
  assign bus.dig1      = dig1_q;
  assign bus.dig2      = dig2_q;
  assign bus.dig3      = dig3_q;
  assign bus.blank     = blank_q;
  // Pulse lives in the final dwell cycle itself, so it must be decoded
  // from the current count; gating by the live requests keeps it quiet
  // when an alarm or a request drop takes that edge instead.
  assign bus.page_done = expire;

endmodule
`default_nettype wire

// File: tb/tb_disp_page_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_disp_page_arbiter
//  Description : Scoreboard bench for disp_page_arbiter with a page-level
//                reference model; directed scenarios then random traffic.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_disp_page_arbiter;
  localparam int DWELL = 4;
  localparam int BLINK = 3;
  localparam int CW    = 4;

  localparam int P_IDLE  = 0;
  localparam int P_TEMP  = 1;
  localparam int P_STAT  = 2;
  localparam int P_ALARM = 3;

  logic clock = 1'b0;
  logic clr   = 1'b1;

  disp_page_arbiter_if bus ();

  disp_page_arbiter #(.DWELL(DWELL), .BLINK(BLINK), .CW(CW)) dut (
    .clock (clock),
    .clr   (clr),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit         async_chk;
    bit         pd;
    logic [2:0] gnt;
    logic [15:0] digs;   // {dig3,dig2,dig1,dig0}
    logic [3:0] blank;
  } exp_t;

  exp_t sb[$];
  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: which page is shown, which page to return to, and
  // how long the current page and blink half-period have lasted.
  int m_page   = P_IDLE;
  int m_resume = P_TEMP;
  int m_dwell  = 0;
  int m_bcnt   = 0;
  bit m_phase  = 1'b0;

  task automatic model_reset();
    m_page = P_IDLE; m_resume = P_TEMP; m_dwell = 0; m_bcnt = 0; m_phase = 1'b0;
  endtask

  function automatic bit wanted(input logic [2:0] r, input int p);
    return r[p-1] === 1'b1;
  endfunction

  function automatic bit model_pd(input logic [2:0] r);
    return (m_page == P_TEMP || m_page == P_STAT) && wanted(r, m_page)
           && (m_dwell == DWELL - 1) && (r[2] !== 1'b1);
  endfunction

  task automatic model_step(input logic [2:0] r);
    int oth;
    if (m_bcnt == BLINK - 1) begin m_bcnt = 0; m_phase = !m_phase; end
    else m_bcnt++;
    if (r[2] === 1'b1) begin
      if (m_page == P_TEMP || m_page == P_STAT) m_resume = m_page;
      m_page = P_ALARM; m_dwell = 0;
    end else if (m_page == P_IDLE || m_page == P_ALARM) begin
      oth = 3 - m_resume;
      m_page  = wanted(r, m_resume) ? m_resume : (wanted(r, oth) ? oth : P_IDLE);
      m_dwell = 0;
    end else begin
      oth = 3 - m_page;
      if (!wanted(r, m_page)) begin
        m_page = wanted(r, oth) ? oth : P_IDLE; m_dwell = 0;
      end else if (m_dwell == DWELL - 1) begin
        m_dwell = 0;
        if (wanted(r, oth)) m_page = oth;
      end else m_dwell++;
    end
  endtask

  task automatic render(input logic [7:0] t, input logic [3:0] s, input bit w,
                        inout exp_t e);
    e.gnt = (m_page == P_IDLE) ? 3'b000 : 3'(1 << (m_page - 1));
    case (m_page)
      P_TEMP:  begin e.digs = {4'hC, 4'h0, t[7:4], t[3:0]}; e.blank = 4'b0100; end
      P_STAT:  begin e.digs = {12'h000, s}; e.blank = (w && m_phase) ? 4'b1111 : 4'b1110; end
      P_ALARM: begin e.digs = {8'hAA, 4'h0, s}; e.blank = m_phase ? 4'b1111 : 4'b0010; end
      default: begin e.digs = 16'h0000; e.blank = 4'hF; end
    endcase
  endtask

  task automatic step(input bit c, input logic [2:0] r, input logic [7:0] t,
                      input logic [3:0] s, input bit w);
    exp_t e;
    @(negedge clock);
    clr = c; bus.req = r; bus.temp_bcd = t; bus.status = s; bus.warning = w;
    e.async_chk = c;
    if (c) begin
      model_reset();
      e.pd = 1'b0;
    end else begin
      e.pd = model_pd(r);
      model_step(r);
    end
    render(t, s, w, e);
    sb.push_back(e);
  endtask

  task automatic check_outs(input string tag, input exp_t e);
    logic [15:0] digs;
    digs = {bus.dig3, bus.dig2, bus.dig1, bus.dig0};
    n_chk++;
    if (bus.gnt !== e.gnt || digs !== e.digs || bus.blank !== e.blank) begin
      n_fail++;
      $display("FAIL %s @%0t: got gnt=%b digs=%h blank=%b, expected gnt=%b digs=%h blank=%b",
               tag, $time, bus.gnt, digs, bus.blank, e.gnt, e.digs, e.blank);
    end
  endtask

  // Monitor: page_done is checked inside the cycle it belongs to, the
  // registered outputs just after the edge that loads them.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock); #2;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        n_chk++;
        if (bus.page_done !== e.pd) begin
          n_fail++;
          $display("FAIL page_done @%0t: got %b expected %b", $time, bus.page_done, e.pd);
        end
        if (e.async_chk) check_outs("async_reset", e);
        @(posedge clock); #1;
        check_outs(e.async_chk ? "reset_hold" : "outputs", e);
      end
    end
  end

  initial begin : stimulus
    logic [2:0] r;
    logic [7:0] t;
    logic [3:0] s;
    bit         w;
    bus.req = 3'b000; bus.temp_bcd = 8'h00; bus.status = 4'h0; bus.warning = 1'b0;

    // Reset, then idle with no requests.
    repeat (3) step(1'b1, 3'b000, 8'h27, 4'h5, 1'b0);
    repeat (6) step(1'b0, 3'b000, 8'h27, 4'h5, 1'b0);
    // Temperature/status round-robin.
    repeat (14) step(1'b0, 3'b011, 8'h27, 4'h5, 1'b0);
    // Alarm pre-emption and blinking, then resume.
    repeat (12) step(1'b0, 3'b111, 8'h27, 4'h5, 1'b0);
    repeat (14) step(1'b0, 3'b011, 8'h27, 4'h5, 1'b1);
    // Request drops: temperature, then status.
    repeat (3) step(1'b0, 3'b011, 8'h31, 4'h9, 1'b0);
    repeat (3) step(1'b0, 3'b010, 8'h31, 4'h9, 1'b0);
    repeat (3) step(1'b0, 3'b000, 8'h31, 4'h9, 1'b0);
    // Alarm arriving on a dwell-expiry cycle, then reset mid-alarm.
    repeat (4) step(1'b0, 3'b001, 8'h45, 4'h2, 1'b0);
    repeat (4) step(1'b0, 3'b101, 8'h45, 4'h2, 1'b0);
    repeat (2) step(1'b1, 3'b100, 8'h45, 4'h2, 1'b0);
    repeat (2) step(1'b0, 3'b000, 8'h45, 4'h2, 1'b0);

    // Random traffic with slowly changing request levels.
    r = 3'b000; t = 8'h00; s = 4'h0; w = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 5) == 0)  r[0] = ~r[0];
      if ($urandom_range(0, 5) == 0)  r[1] = ~r[1];
      if ($urandom_range(0, 13) == 0) r[2] = ~r[2];
      if ($urandom_range(0, 7) == 0)  w = ~w;
      t = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      s = 4'($urandom);
      step($urandom_range(0, 149) == 0, r, t, s, w);
    end

    @(posedge clock); #3;
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/disp_page_arbiter.md
Name: disp_page_arbiter

Overview:
- Shares the 4-digit seven-segment display between three requesters: temperature readout, system status code, and alarm banner.
- Sits between the sensor/FSM outputs (temperature BCD, alarm, warning, status) and the seven-segment scanner.
- Alarm pre-empts everything. Temperature and status round-robin on a dwell timer. Alarm and warning pages blink.
- Outputs are registered digit codes plus a per-digit blank mask consumed by the scanner.

Parameters:
- DWELL, 25000000: clock cycles a page is held before round-robin rotation (min 2).
- BLINK, 12500000: clock cycles per blink half-period (min 1).
- CW, 25: width of the dwell and blink counters; must hold DWELL-1 and BLINK-1.

Ports:
- clock  in  1  system clock, all logic on rising edge
- clr  in  1  asynchronous active-high reset
- req  in  3  page requests, level: bit0 temperature, bit1 status, bit2 alarm
- temp_bcd  in  8  two BCD digits of temperature, [7:4] tens, [3:0] units
- status  in  4  FSM status code
- warning  in  1  warning flag; makes the status digit blink
- gnt  out  3  one-hot grant, same bit order as req; 0 when idle
- dig0  out  4  rightmost digit code
- dig1  out  4  digit code
- dig2  out  4  digit code
- dig3  out  4  leftmost digit code
- blank  out  4  per-digit blank, 1 = off, bit n for digN
- page_done  out  1  one-cycle pulse when a temperature/status dwell expires

Behaviour:
- Reset: clr is asynchronous, active-high; clock is clock.
  - While clr=1: state IDLE, gnt=000, dig0..dig3=0, blank=4'hF, page_done=0, dwell and blink counters 0, blink_phase 0, resume pointer = TEMP.
  - Reset mid-page returns to IDLE immediately, with no pulse.
- States: IDLE, TEMP, STAT, ALARM.
  - gnt, dig and blank are registered and updated on the same edge as state.
  - Latency from a req change to the gnt change is 1 cycle.
- Priority rule: req[2]=1 forces ALARM on the next edge from any state.
  - On entering ALARM, the resume pointer records the pre-empted page (TEMP or STAT). Entered from IDLE, the pointer is unchanged.
  - The dwell counter is cleared.
- ALARM exit: on req[2]=0, next state is:
  - the resume-pointer page if its req bit is 1;
  - else the other of TEMP/STAT if requested;
  - else IDLE.
  - The dwell counter restarts at 0.
- IDLE: leaves when any request is present.
  - req[2] goes to ALARM.
  - Else if req0 and req1 are both set, go to the resume-pointer page.
  - Else go to the single requested page.
- TEMP/STAT dwell:
  - The counter increments each cycle in the page.
  - At count DWELL-1: page_done=1 for that cycle and the counter wraps to 0.
  - If the other page is requested, the state switches on that same edge; otherwise it stays.
- Own request drops while in TEMP/STAT: next edge goes to the other page if requested, else IDLE. Counter cleared; no page_done.
- Simultaneous events: alarm wins over dwell expiry and request drop. page_done is not asserted on the edge an alarm pre-empts.
- Blink: a free-running counter toggles blink_phase every BLINK cycles. Phase 0 = visible, phase 1 = blanked.
- Page content (sampled every cycle while granted):
  - TEMP: dig1=temp_bcd[7:4], dig0=temp_bcd[3:0], dig3=4'hC, dig2=0. blank=4'b0100.
  - STAT: dig0=status, others 0. blank=4'b1110. If warning=1 and blink_phase=1, blank=4'b1111.
  - ALARM: dig3=dig2=4'hA, dig1=0, dig0=status. blank=4'b0010 when blink_phase=0, 4'b1111 when blink_phase=1.
  - IDLE: digits 0, blank=4'hF.
- gnt is always one-hot or zero, never more than one bit set.

Test Plan:
1. Reset, then release with req=000 -> gnt=000, blank=4'hF, all digits 0, page_done never pulses.
2. DWELL=4; req=011, temp_bcd=8'h27 -> TEMP granted 1 cycle after the request. page_done at the 4th cycle of each page, then gnt alternates 001/010 every 4 cycles. In TEMP: dig1=2, dig0=7, dig3=C, blank=0100.
3. In STAT (status=4'h5), assert req[2] -> next edge gnt=100, dig3=dig2=A, dig0=5. Drop req[2] -> gnt returns to 010 (STAT resumed) with the dwell counter restarted.
4. BLINK=3; ALARM held 12 cycles -> blank alternates 0010 for 3 cycles and 1111 for 3 cycles. In STAT with warning=1, only the blank pattern 1110/1111 toggles.
5. In TEMP with req=011, drop req0 at dwell count 2 -> next edge gnt=010, no page_done. Then drop req1 -> IDLE, blank=4'hF.
6. req[2] rises on the same cycle the dwell expires -> ALARM entered, page_done stays 0. Assert clr mid-ALARM -> immediately gnt=000, blank=4'hF.
